request_arbiter: RTL
====================

# request_arbiter

Round-robin arbiter that shares one downstream resource among eight requesters. It uses the same ordering as the team's 8-bit priority encoder: highest index first, with the starting point rotated past the last winner. It issues a registered one-hot grant, holds that grant until the owner signals DONE, withdraws its request or exceeds a hold limit, and then inserts one release cycle before re-arbitrating. It sits between the requesting datapath units and the shared resource.

## Interface
- HOLD_MAX, default 255: maximum grant length in cycles, range 1–255 (8-bit counter); 0 disables the timeout.
- CLK  input  1  rising-edge clock, the only clock.
- RST  input  1  synchronous, active-high reset.
- REQ  input  8  request vector; bit i = requester i; level-sensitive.
- DONE  input  1  owner finished; sampled only in GRANT.
- GNT  output  8  one-hot grant, registered; all-zero when no owner.
- GNT_ID  output  3  binary index of the current owner; valid when VALID=1.
- VALID  output  1  high while GNT is non-zero (state GRANT).
- TIMEOUT  output  1  one-cycle pulse, high in the REL cycle that follows a forced release.
- ZERO  output  1  combinational, 1 when REQ == 0.

## Operation
- States: IDLE, GRANT, REL. Registers: state, GNT, GNT_ID, LAST[2:0] (last winner), CNT[7:0], TIMEOUT.
- Search order from LAST = k is k-1, k-2, …, 0, 7, …, k (indices mod 8), descending.
  - The winner is the first index in that order with REQ set.
  - With LAST=0 the order is 7..0, identical to the priority encoder.
  - k itself is searched last, so a sole requester can win repeatedly.
- IDLE or REL, REQ≠0: next state GRANT.
  - GNT ← one-hot(winner), GNT_ID ← winner, LAST ← winner, CNT ← 0.
- IDLE or REL, REQ=0: next state IDLE. GNT, GNT_ID and LAST hold.
- GRANT, release conditions (priority order):
  - DONE=1: normal release.
  - REQ[GNT_ID]=0: withdrawal, treated as a normal release.
  - HOLD_MAX≠0 and CNT==HOLD_MAX-1: forced release, TIMEOUT ← 1.
  - On any release: next state REL, GNT ← 0.
  - Otherwise stay in GRANT with CNT ← CNT+1; CNT saturates at 255.
- DONE and timeout in the same cycle: DONE wins and TIMEOUT stays 0.
- DONE in IDLE or REL: ignored.
- REL always lasts exactly one cycle with GNT=0. Arbitration happens in the REL cycle itself.
- TIMEOUT is cleared on every edge except the forced-release edge.
- Requests arriving or changing while in GRANT never preempt the owner.
- GNT_ID and LAST hold their last value through REL and IDLE.

## Timing
- Reset (RST high at an edge, including mid-grant): state IDLE, GNT=0, GNT_ID=0, VALID=0, TIMEOUT=0, LAST=0, CNT=0. GNT is low from the cycle after that edge.
- Grant latency: REQ first sampled high in IDLE at edge n → GNT high after edge n, i.e. one cycle.
- Release latency: DONE sampled at edge m → GNT=0 in cycle m+1 (REL).
  - Next GNT appears after edge m+1 when REQ≠0, so the gap is exactly one cycle.
- Maximum grant length: HOLD_MAX cycles of GNT high. TIMEOUT is high in the REL cycle immediately after.
- ZERO has no latency (combinational from REQ). All other outputs are registered.
- Throughput: with continuous requests, one grant every (hold + 1) cycles.

## Test plan
- Reset/basic:
  - Stimulus: RST for 2 cycles, then REQ=8'b0000_0100 and DONE after 3 grant cycles.
  - Required: GNT=0 during reset; GNT=8'b0000_0100 and GNT_ID=2 one cycle after REQ; GNT=0 one cycle after DONE; ZERO=1 whenever REQ=0.
- Round-robin fairness:
  - Stimulus: REQ=8'hFF held; DONE pulsed on the first cycle of each grant.
  - Required: GNT_ID sequence 7,6,5,4,3,2,1,0,7; each grant separated by exactly one GNT=0 cycle.
- Rotation skip:
  - Stimulus: LAST=5 (after a grant to 5); then REQ=8'b1010_0001.
  - Required: next GNT_ID=0, then 7, then 5.
- Timeout:
  - Stimulus: HOLD_MAX=4; REQ[3]=1 held; DONE never asserted.
  - Required: GNT[3] high exactly 4 cycles, TIMEOUT=1 for exactly 1 cycle (the REL cycle), then GNT[3] again.
  - Variant: DONE on the 4th cycle → TIMEOUT stays 0.
- Withdrawal and mid-grant reset:
  - Stimulus (withdrawal): owner 6 drops REQ[6] in GRANT.
  - Required: GNT=0 next cycle, TIMEOUT=0.
  - Stimulus (reset): RST asserted while GNT=8'h10.
  - Required: GNT=0, LAST=0 after the edge; the next grant with REQ=8'hFF goes to 7.
- No preemption:
  - Stimulus: owner 1 in GRANT; REQ[7] rises.
  - Required: GNT stays 8'b0000_0010 until DONE, then 7 is granted after the REL cycle.

Source files
------------

// File: rtl/request_arbiter.sv
// ----------------------------------------------------------------------------
// request_arbiter
//
// Round-robin arbiter sharing one downstream resource among eight requesters.
// Search order is descending (highest index first), rotated so the search
// starts just below the last winner; the last winner itself is searched last,
// so a lone requester can win back to back. A grant is held until the owner
// signals done, drops its request, or reaches the hold limit. Every grant is
// followed by one release cycle (GNT all-zero) in which the next winner is
// picked.
//
// Parameters
//   HOLD_MAX  maximum grant length in cycles (1..255); 0 disables the timeout
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   req      [7:0] level-sensitive request vector, bit i = requester i
//   done     owner finished; only looked at while a grant is active
//   gnt      [7:0] registered one-hot grant, zero when nobody owns the resource
//   gnt_id   [2:0] binary index of the owner (holds its value while idle)
//   valid    high while a grant is active
//   timeout  one-cycle pulse in the release cycle after a forced release
//   zero     combinational, high when req is all-zero
// ----------------------------------------------------------------------------
module request_arbiter #(
   parameter int HOLD_MAX = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       valid,
   output logic       timeout,
   output logic       zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      REL   = 2'd2
   } state_t;

   // Forced release fires on the edge where the count reaches HOLD_MAX-1,
   // which gives exactly HOLD_MAX cycles of grant.
   localparam bit         HOLD_EN   = (HOLD_MAX != 0);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   state_t     state_reg;
   logic [7:0] gnt_reg;
   logic [2:0] gnt_id_reg;
   logic [2:0] last_reg;
   logic [7:0] cnt_reg;
   logic       valid_reg;
   logic       timeout_reg;

   // ------------------------------------------------------------------------
   // Winner search. Candidate gi (0..7) is index last-(gi+1) mod 8, so
   // candidate 0 is just below the last winner and candidate 7 is the last
   // winner itself. The lowest-numbered candidate with a request wins.
   // ------------------------------------------------------------------------
   logic [2:0] cand_idx [8];
   logic [7:0] cand_hit;
   logic [2:0] win_next;
   logic [7:0] win_onehot_next;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_cand
         assign cand_idx[gi] = last_reg - 3'(gi + 1);
         assign cand_hit[gi] = req[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      win_next = '0;
      // Walk from the lowest priority up so the highest-priority hit
      // is the final assignment.
      for (int j = 7; j >= 0; j--) begin
         if (cand_hit[j]) begin
            win_next = cand_idx[j];
         end
      end
      win_onehot_next = 8'b1 << win_next;
   end

   // Withdrawal counts as a normal release, same as done.
   logic owner_released;
   logic hold_expired;

   assign owner_released = done || !req[gnt_id_reg];
   assign hold_expired   = HOLD_EN && (cnt_reg == HOLD_LAST);

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         gnt_reg     <= '0;
         gnt_id_reg  <= '0;
         last_reg    <= '0;
         cnt_reg     <= '0;
         valid_reg   <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         // Pulse: only the forced-release edge sets it.
         timeout_reg <= 1'b0;

         case (state_reg)
            IDLE, REL: begin
               // Arbitration happens in REL too, so consecutive grants
               // are separated by exactly one empty cycle.
               if (req != 8'h00) begin
                  state_reg  <= GRANT;
                  gnt_reg    <= win_onehot_next;
                  gnt_id_reg <= win_next;
                  last_reg   <= win_next;
                  cnt_reg    <= '0;
                  valid_reg  <= 1'b1;
               end else begin
                  state_reg <= IDLE;
                  gnt_reg   <= '0;
                  valid_reg <= 1'b0;
               end
            end

            GRANT: begin
               if (owner_released) begin
                  // Checked before the hold limit so done wins a tie and
                  // no timeout is reported.
                  state_reg <= REL;
                  gnt_reg   <= '0;
                  valid_reg <= 1'b0;
               end else if (hold_expired) begin
                  state_reg   <= REL;
                  gnt_reg     <= '0;
                  valid_reg   <= 1'b0;
                  timeout_reg <= 1'b1;
               end else if (cnt_reg != 8'hFF) begin
                  // Saturate so a disabled timeout never wraps.
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end

            default: begin
               state_reg <= IDLE;
               gnt_reg   <= '0;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign gnt     = gnt_reg;
   assign gnt_id  = gnt_id_reg;
   assign valid   = valid_reg;
   assign timeout = timeout_reg;
   assign zero    = (req == 8'h00);

endmodule
